// File: rtl/spi_frame_sequencer_if.sv
// Signal bundle between the counter/byte-engine side and the SPI frame sequencer.
// The master modport is the environment, the slave modport is the sequencer.
interface spi_frame_sequencer_if;
  logic        send;
  logic [13:0] data;
  logic        clr_err;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        cs_n;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic [7:0]  drop_cnt;

  modport master (
    output send, data, clr_err, tx_done,
    input  tx_start, tx_byte, cs_n, busy, frame_done, err, drop_cnt
  );

  modport slave (
    input  send, data, clr_err, tx_done,
    output tx_start, tx_byte, cs_n, busy, frame_done, err, drop_cnt
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Sequences a 14-bit counter value as a two-byte SPI frame through a byte engine,
// with programmable CS setup/gap/hold, a one-deep request buffer and a wait timeout.
module spi_frame_sequencer #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                  clk,
  input logic                  reset,
  spi_frame_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StSetup, StSendHi, StWaitHi, StGap, StSendLo, StWaitLo, StHold
  } state_e;

  localparam int unsigned MaxSg  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int unsigned MaxHt  = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
  localparam int unsigned MaxCyc = (MaxSg > MaxHt) ? MaxSg : MaxHt;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [13:0]     frame_q, frame_d;
  logic [7:0]      byte_q, byte_d;
  logic            pend_q, pend_d;
  logic [13:0]     pend_data_q, pend_data_d;
  logic [7:0]      drop_q, drop_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            drop_inc;
  logic            timeout;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    frame_d     = frame_q;
    byte_d      = byte_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    drop_d      = drop_q;
    err_d       = err_q;
    done_d      = 1'b0;
    drop_inc    = 1'b0;
    timeout     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.send) begin
          // Fresh data wins over a buffered request; the buffered one counts as lost.
          frame_d = bus.data;
          state_d = StSetup;
          if (pend_q) begin
            pend_d   = 1'b0;
            drop_inc = 1'b1;
          end
        end else if (pend_q) begin
          frame_d = pend_data_q;
          pend_d  = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SETUP_CYC - 1)) begin
          state_d = StSendHi;
          byte_d  = {2'b00, frame_q[13:8]};
        end
      end
      StSendHi: begin
        state_d = StWaitHi;
        cnt_d   = '0;
      end
      StWaitHi: begin
        if (bus.tx_done) begin
          state_d = StGap;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          state_d = StIdle;
          timeout = 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYC - 1)) begin
          state_d = StSendLo;
          byte_d  = frame_q[7:0];
        end
      end
      StSendLo: begin
        state_d = StWaitLo;
        cnt_d   = '0;
      end
      StWaitLo: begin
        if (bus.tx_done) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          state_d = StIdle;
          timeout = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(HOLD_CYC - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.send && (state_q != StIdle)) begin
      pend_data_d = bus.data;
      pend_d      = 1'b1;
      if (pend_q) drop_inc = 1'b1;
    end

    if (drop_inc && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    if (timeout) begin
      err_d = 1'b1;
    end else if (bus.clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      frame_q     <= '0;
      byte_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      drop_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      byte_q      <= byte_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign bus.tx_start   = (state_q == StSendHi) || (state_q == StSendLo);
  assign bus.tx_byte    = byte_q;
  assign bus.cs_n       = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = done_q;
  assign bus.err        = err_q;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer: expected bytes are queued at stimulus time
// and a monitor checks them on each byte-engine start; a stub engine answers with done.
module tb_spi_frame_sequencer;
  logic clk = 1'b0;
  logic reset;

  spi_frame_sequencer_if bus ();

  spi_frame_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         fd_count = 0;
  bit         withhold = 1'b0;
  bit         stray_req = 1'b0;
  int         stub_cnt = 0;
  int         stub_idx = 0;
  bit         stub_lo = 1'b0;
  logic       prev_cs = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [13:0] w);
    exp_q.push_back({2'b00, w[13:8]});
    exp_q.push_back(w[7:0]);
  endtask

  task automatic send_req(input logic [13:0] w);
    bus.send = 1'b1;
    bus.data = w;
    tick();
    bus.send = 1'b0;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return bus.tx_start === 1'b1;
      1:       return bus.tx_done === 1'b1;
      2:       return bus.frame_done === 1'b1;
      3:       return bus.cs_n === 1'b1;
      default: return bus.cs_n === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string name, output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      tick();
      if (cond(sel)) at = cyc;
    end
    if (at < 0) begin
      total++;
      bad++;
      $display("FAIL %s: no event within %0d cycles", name, limit);
    end
  endtask

  // Monitor: scoreboard pop on every byte start, frame_done must coincide with CS rising.
  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start: got byte %0h want no start", bus.tx_byte);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", 32'(bus.tx_byte), 32'(e));
      end
    end
    if (bus.frame_done === 1'b1) begin
      fd_count++;
      check("done_cs_rise", 32'({prev_cs, bus.cs_n}), 32'h1);
    end
    prev_cs = bus.cs_n;
  end

  // Stub byte engine: done 16 cycles after start; may withhold the low-byte done.
  always @(negedge clk) begin
    bus.tx_done = 1'b0;
    if (reset === 1'b1) begin
      stub_cnt = 0;
    end else begin
      if (stray_req) bus.tx_done = 1'b1;
      if (bus.cs_n === 1'b1) stub_idx = 0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0 && !(withhold && stub_lo)) bus.tx_done = 1'b1;
      end
      if (bus.tx_start === 1'b1) begin
        stub_idx++;
        stub_lo  = (stub_idx == 2);
        stub_cnt = 16;
      end
    end
  end

  initial begin
    int c0, t, m, k, fd, a, fd_before;
    reset       = 1'b1;
    bus.send    = 1'b0;
    bus.data    = '0;
    bus.clr_err = 1'b0;
    repeat (3) tick();
    check("rst_cs_n", 32'(bus.cs_n), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_tx_start", 32'(bus.tx_start), 32'h0);
    check("rst_tx_byte", 32'(bus.tx_byte), 32'h0);
    check("rst_frame_done", 32'(bus.frame_done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_drop", 32'(bus.drop_cnt), 32'h0);
    reset = 1'b0;
    tick();

    // Single frame with latency checks
    expect_frame(14'h2A5C);
    c0 = cyc;
    send_req(14'h2A5C);
    check("cs_low_next", 32'(bus.cs_n), 32'h0);
    check("busy_next", 32'(bus.busy), 32'h1);
    wait_for(0, 20, "hi_start", t);
    check("hi_start_lat", 32'(t - c0), 32'd3);
    wait_for(1, 40, "hi_done", m);
    wait_for(0, 20, "lo_start", t);
    check("lo_start_lat", 32'(t - m), 32'd3);
    wait_for(1, 40, "lo_done", k);
    wait_for(2, 20, "frame_done", fd);
    check("hold_lat", 32'(fd - k), 32'd3);
    check("cs_low_len", 32'(fd - (c0 + 1)), 32'd40);

    // Counter sweep 0..5
    for (int i = 0; i < 6; i++) begin
      expect_frame(14'(i));
      send_req(14'(i));
      repeat (199) tick();
    end
    check("sweep_drop", 32'(bus.drop_cnt), 32'h0);
    check("sweep_err", 32'(bus.err), 32'h0);
    check("sweep_frames", 32'(fd_count), 32'd7);
    check("sweep_queue", 32'(exp_q.size()), 32'd0);

    // Back-to-back: second request overwritten by third
    expect_frame(14'h0011);
    expect_frame(14'h0033);
    send_req(14'h0011);
    repeat (4) tick();
    send_req(14'h0022);
    repeat (9) tick();
    send_req(14'h0033);
    wait_for(2, 100, "b2b_fd1", fd);
    tick();
    check("b2b_cs_low", 32'(bus.cs_n), 32'h0);
    wait_for(2, 100, "b2b_fd2", fd);
    check("b2b_drop", 32'(bus.drop_cnt), 32'h1);
    check("b2b_queue", 32'(exp_q.size()), 32'd0);

    // Timeout in WAIT_LO
    withhold  = 1'b1;
    fd_before = fd_count;
    expect_frame(14'h1234);
    send_req(14'h1234);
    wait_for(0, 20, "to_hi_start", t);
    wait_for(0, 60, "to_lo_start", t);
    wait_for(3, 1100, "to_abort", a);
    check("to_len", 32'(a - t), 32'd1025);
    check("to_err", 32'(bus.err), 32'h1);
    check("to_busy", 32'(bus.busy), 32'h0);
    check("to_no_done", 32'(fd_count), 32'(fd_before));
    withhold = 1'b0;
    expect_frame(14'h0777);
    send_req(14'h0777);
    wait_for(2, 100, "to_next_fd", fd);
    check("to_err_sticky", 32'(bus.err), 32'h1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("to_err_clr", 32'(bus.err), 32'h0);

    // Reset during GAP with a pending request
    exp_q.push_back(8'h01);
    send_req(14'h0155);
    repeat (3) tick();
    send_req(14'h0AAA);
    wait_for(1, 40, "rst_hi_done", m);
    tick();
    check("rst_gap_cs", 32'(bus.cs_n), 32'h0);
    reset = 1'b1;
    tick();
    check("midrst_cs_n", 32'(bus.cs_n), 32'h1);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_drop", 32'(bus.drop_cnt), 32'h0);
    reset     = 1'b0;
    fd_before = fd_count;
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    tick();
    check("stray_cs_n", 32'(bus.cs_n), 32'h1);
    check("stray_busy", 32'(bus.busy), 32'h0);
    check("stray_tx_start", 32'(bus.tx_start), 32'h0);
    repeat (60) tick();
    check("midrst_no_pending", 32'(bus.busy), 32'h0);
    check("midrst_no_done", 32'(fd_count), 32'(fd_before));
    check("midrst_queue", 32'(exp_q.size()), 32'd0);

    // Saturation: 1 store + 300 overwrites while a frame hangs in WAIT_LO
    withhold = 1'b1;
    expect_frame(14'h0100);
    send_req(14'h0100);
    for (int i = 0; i <= 300; i++) begin
      bus.send = 1'b1;
      bus.data = 14'(i);
      tick();
    end
    bus.send = 1'b0;
    withhold = 1'b0;
    check("sat_drop", 32'(bus.drop_cnt), 32'd255);
    expect_frame(14'd300);
    wait_for(3, 1200, "sat_abort", a);
    wait_for(2, 200, "sat_pending_fd", fd);
    check("sat_drop_hold", 32'(bus.drop_cnt), 32'd255);
    check("sat_err", 32'(bus.err), 32'h1);

    tick();
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
